// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU execution-pacing logic: FSM state encoding,
// display mode encoding and the default run-mode divide ratio.
package cpu_ctrl_pkg;

    localparam int unsigned RUN_DIV_DEFAULT = 50_000_000;
    localparam int unsigned MODE_W          = 2;

    typedef enum logic [MODE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef logic [MODE_W-1:0] mode_t;

    // The display mux shows the raw state code, so mode and state share an encoding.
    function automatic mode_t state_to_mode(input state_t st);
        return mode_t'(st);
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_pulse_div.sv
// Modulo-RUN_DIV counter for run-mode pacing; tick is high for the one cycle
// the count sits at RUN_DIV-1 while enabled.
module pulse_div #(
    parameter int unsigned RUN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == DIV_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tick = en && (cnt == DIV_MAX);

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable pacing: single-step on button press or free-run at RUN_DIV.
// Define CPU_STEP_CNT_EN to build the step_count counter; otherwise it reads 0.
module cpu_step_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned RUN_DIV = RUN_DIV_DEFAULT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic             halt,
    output logic             cpu_ce,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] step_count
);

    state_t state, state_nx;
    logic   btn_q;
    logic   rise;
    logic   trig;
    logic   run_active;
    logic   div_tick;

    assign rise = step_btn & ~btn_q;

    // Divider enable is kept outside the FSM block so tick -> trig is not a comb loop.
    assign run_active = (state == ST_RUN) && run_sw && !halt;

    pulse_div #(
        .RUN_DIV (RUN_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!run_active),
        .en    (run_active),
        .tick  (div_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            btn_q  <= 1'b0;
            cpu_ce <= 1'b0;
        end else begin
            state  <= state_nx;
            btn_q  <= step_btn;
            cpu_ce <= trig;
        end
    end

    always_comb begin
        state_nx = state;
        trig     = 1'b0;
        if (halt) begin
            state_nx = ST_HALT;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (run_sw) begin
                        state_nx = ST_RUN;
                    end else if (rise) begin
                        state_nx = ST_ARMED;
                        trig     = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!step_btn) begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!run_sw) begin
                        state_nx = ST_IDLE;
                    end else begin
                        trig = div_tick;
                    end
                end
                ST_HALT: begin
                    state_nx = ST_HALT;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    assign mode = state_to_mode(state);

`ifdef CPU_STEP_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (trig) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign step_count = cnt_q;
`else
    assign step_count = '0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl with RUN_DIV=4, CNT_W=4: directed
// scenarios followed by randomized stimulus, all checked against a rule model.
module tb_cpu_step_ctrl;

    localparam int RDIV = 4;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          step_btn;
    logic          run_sw;
    logic          halt;
    logic          cpu_ce;
    logic [1:0]    mode;
    logic [CW-1:0] step_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode as a number, run phase as elapsed cycles mod RDIV.
    int m_mode  = 0;
    int m_phase = 0;
    int m_prev  = 0;
    int m_ce    = 0;
    int m_count = 0;

    int pulses;

    cpu_step_ctrl #(
        .RUN_DIV (RDIV),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_btn   (step_btn),
        .run_sw     (run_sw),
        .halt       (halt),
        .cpu_ce     (cpu_ce),
        .mode       (mode),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input int r, input int b, input int rs, input int h);
        int pulse;
        pulse = 0;
        if (r == 0) begin
            m_mode = 0; m_phase = 0; m_prev = 0; m_ce = 0; m_count = 0;
            return;
        end
        if (h != 0) begin
            m_mode = 3; m_phase = 0;
        end else if (m_mode == 0) begin
            if (rs != 0) begin
                m_mode = 2; m_phase = 0;
            end else if (b != 0 && m_prev == 0) begin
                m_mode = 1; pulse = 1;
            end
        end else if (m_mode == 1) begin
            if (b == 0) m_mode = 0;
        end else if (m_mode == 2) begin
            if (rs == 0) begin
                m_mode = 0; m_phase = 0;
            end else begin
                m_phase = (m_phase + 1) % RDIV;
                if (m_phase == 0) pulse = 1;
            end
        end
        m_ce = pulse;
`ifdef CPU_STEP_CNT_EN
        m_count = (m_count + pulse) % (1 << CW);
`else
        m_count = 0;
`endif
        m_prev = b;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs are already set; apply model at the edge, check #1 after.
    task automatic cyc();
        @(posedge clk);
        model_edge(int'(rst_n), int'(step_btn), int'(run_sw), int'(halt));
        #1;
        chk("cpu_ce", int'(cpu_ce), m_ce);
        chk("mode", int'(mode), m_mode);
        chk("step_count", int'(step_count), m_count);
        if (cpu_ce === 1'b1) pulses++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst_n = 1'b0; step_btn = 1'b0; run_sw = 1'b0; halt = 1'b0;
        #2;
        run_cycles(2);
        rst_n = 1'b1;
        run_cycles(2);

        // Single press held 10 cycles then released.
        pulses = 0;
        step_btn = 1'b1;
        cyc();
        chk("press_mode_armed", int'(mode), 1);
        run_cycles(9);
        step_btn = 1'b0;
        run_cycles(3);
        chk("press_one_pulse", pulses, 1);
        chk("press_back_idle", int'(mode), 0);

        // Free-run for 13 cycles: pulses at 4, 8, 12 after entry.
        pulses = 0;
        run_sw = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            cyc();
            chk("run_pulse_pos", int'(cpu_ce), (i > 1 && ((i - 1) % RDIV) == 0) ? 1 : 0);
        end
        chk("run_three_pulses", pulses, 3);
        run_sw = 1'b0;
        pulses = 0;
        run_cycles(6);
        chk("run_exit_idle", int'(mode), 0);
        chk("run_exit_no_pulse", pulses, 0);

        // Run and rise on the same edge: run wins, later presses ignored.
        pulses = 0;
        run_sw = 1'b1; step_btn = 1'b1;
        cyc();
        chk("run_over_rise_mode", int'(mode), 2);
        chk("run_over_rise_ce", int'(cpu_ce), 0);
        step_btn = 1'b0;
        run_cycles(1);
        step_btn = 1'b1;
        run_cycles(2);
        chk("run_btn_ignored", pulses, 0);
        step_btn = 1'b0;
        run_sw = 1'b0;
        run_cycles(2);

        // Halt in the cycle the divider reaches its last count.
        run_sw = 1'b1;
        cyc();
        for (int i = 0; i < 10 && m_phase != RDIV - 1; i++) cyc();
        chk("halt_setup_phase", m_phase, RDIV - 1);
        pulses = 0;
        halt = 1'b1;
        cyc();
        chk("halt_no_pulse", int'(cpu_ce), 0);
        chk("halt_mode", int'(mode), 3);
        halt = 1'b0;
        step_btn = 1'b1; run_sw = 1'b0;
        run_cycles(2);
        step_btn = 1'b0; run_sw = 1'b1;
        run_cycles(2);
        run_sw = 1'b0;
        run_cycles(1);
        chk("halt_sticky", int'(mode), 3);
        chk("halt_sticky_pulses", pulses, 0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("halt_reset_mode", int'(mode), 0);
        chk("halt_reset_count", int'(step_count), 0);

        // Sixteen presses wrap the counter.
        for (int p = 0; p < 16; p++) begin
            step_btn = 1'b1;
            run_cycles(2);
            step_btn = 1'b0;
            run_cycles(2);
`ifdef CPU_STEP_CNT_EN
            if (p == 14) chk("count_15", int'(step_count), 15);
`else
            if (p == 14) chk("count_15", int'(step_count), 0);
`endif
        end
        chk("count_wrap", int'(step_count), 0);

        // Reset while cpu_ce is high.
        step_btn = 1'b1;
        cyc();
        chk("pre_reset_ce", int'(cpu_ce), 1);
        rst_n = 1'b0;
        cyc();
        chk("reset_ce_low", int'(cpu_ce), 0);
        chk("reset_mode", int'(mode), 0);
        chk("reset_count", int'(step_count), 0);
        rst_n = 1'b1;
        step_btn = 1'b0;
        run_cycles(2);

        // Randomized stimulus with rare halts and resets.
        for (int i = 0; i < 600; i++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            halt     = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 15) == 0) run_sw = ~run_sw;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
